// File: rtl/bscan_user_responder_if.sv
// S_BSCAN bundle between the debug hub (master) and a user-register endpoint (slave).
//   drck/runtest/tms     : carried for completeness, ignored by the endpoint
//   reset/sel/capture/shift/update/tdi/tck/bscanid_en : TAP-side controls, async to fabric
//   bscanid              : endpoint ID returned to the hub
//   tdo                  : serial data back to the hub
interface bscan_user_responder_if;
    logic        drck;
    logic        runtest;
    logic        tms;
    logic        reset;
    logic        sel;
    logic        capture;
    logic        shift;
    logic        update;
    logic        tdi;
    logic        tck;
    logic        bscanid_en;
    logic [31:0] bscanid;
    logic        tdo;

    modport master (
        output drck, runtest, tms, reset, sel, capture, shift, update, tdi, tck, bscanid_en,
        input  bscanid, tdo
    );

    modport slave (
        input  drck, runtest, tms, reset, sel, capture, shift, update, tdi, tck, bscanid_en,
        output bscanid, tdo
    );
endinterface

// File: rtl/bscan_user_responder.sv
// JTAG user data register implemented in the fabric clock domain. All BSCAN controls are
// oversampled on aclk; TCK edges are detected from the synchronized TCK.
//   aclk, aresetn  : fabric clock, async active-low reset
//   s_bscan        : S_BSCAN bundle (slave side)
//   status_in      : word loaded on CAPTURE (unless ID mode)
//   ctrl_out/ctrl_valid/ctrl_ready : update word handed to fabric with valid/ready
//   overrun, len_err : sticky error flags, cleared by err_clr
module bscan_user_responder #(
    parameter int unsigned C_DR_WIDTH    = 32,
    parameter logic [31:0] C_BSCANID     = 32'h04C0_0101,
    parameter int unsigned C_SYNC_STAGES = 2
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    bscan_user_responder_if.slave   s_bscan,
    input  logic [C_DR_WIDTH-1:0]   status_in,
    output logic [C_DR_WIDTH-1:0]   ctrl_out,
    output logic                    ctrl_valid,
    input  logic                    ctrl_ready,
    output logic                    overrun,
    output logic                    len_err,
    input  logic                    err_clr
);

    localparam int unsigned CW = $clog2(C_DR_WIDTH + 2);
    localparam logic [CW-1:0] C_CNT_FULL = CW'(C_DR_WIDTH);
    localparam logic [CW-1:0] C_CNT_MAX  = CW'(C_DR_WIDTH + 1);

    // Bit order: {bscanid_en, tck, tdi, update, shift, capture, sel, reset}
    logic [7:0]            w_async;
    logic [7:0]            r_sync [C_SYNC_STAGES];
    logic [7:0]            w_synced;
    logic                  r_tck_d;

    logic [C_DR_WIDTH-1:0] r_shreg,    w_shreg_nxt;
    logic [CW-1:0]         r_cnt,      w_cnt_nxt;
    logic                  r_tdo,      w_tdo_nxt;
    logic [C_DR_WIDTH-1:0] r_ctrl_out, w_out_nxt;
    logic                  r_ctrl_valid, w_valid_nxt;
    logic                  r_overrun,  w_ovr_nxt;
    logic                  r_len_err,  w_lerr_nxt;

    logic w_reset_s, w_sel_s, w_capture_s, w_shift_s, w_update_s, w_tdi_s, w_tck_s, w_id_s;
    logic w_rise, w_fall, w_hs;
    logic w_unused_bscan;

    assign w_async = {s_bscan.bscanid_en, s_bscan.tck, s_bscan.tdi, s_bscan.update,
                      s_bscan.shift, s_bscan.capture, s_bscan.sel, s_bscan.reset};
    assign w_unused_bscan = s_bscan.drck ^ s_bscan.runtest ^ s_bscan.tms;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < C_SYNC_STAGES; i++) r_sync[i] <= '0;
            r_tck_d <= 1'b0;
        end else begin
            r_sync[0] <= w_async;
            for (int i = 1; i < C_SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_tck_d <= w_synced[6];
        end
    end

    assign w_synced = r_sync[C_SYNC_STAGES-1];
    assign {w_id_s, w_tck_s, w_tdi_s, w_update_s, w_shift_s, w_capture_s, w_sel_s, w_reset_s}
        = w_synced;

    assign w_rise = w_tck_s & ~r_tck_d;
    assign w_fall = ~w_tck_s & r_tck_d;
    assign w_hs   = r_ctrl_valid & ctrl_ready;

    always_comb begin
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_tdo_nxt   = r_tdo;
        w_out_nxt   = r_ctrl_out;
        w_valid_nxt = r_ctrl_valid & ~w_hs;
        // Clear first so a same-cycle setting event overrides it.
        w_ovr_nxt   = r_overrun & ~err_clr;
        w_lerr_nxt  = r_len_err & ~err_clr;

        if (w_reset_s) begin
            w_shreg_nxt = '0;
            w_cnt_nxt   = '0;
            w_tdo_nxt   = 1'b0;
        end else begin
            if (w_rise && w_sel_s) begin
                if (w_capture_s) begin
                    w_shreg_nxt = w_id_s ? C_DR_WIDTH'(C_BSCANID) : status_in;
                    w_cnt_nxt   = '0;
                end else if (w_shift_s) begin
                    w_shreg_nxt = {w_tdi_s, r_shreg[C_DR_WIDTH-1:1]};
                    if (r_cnt != C_CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
                end else if (w_update_s) begin
                    if (r_cnt == C_CNT_FULL) begin
                        w_out_nxt   = r_shreg;
                        w_valid_nxt = 1'b1;
                        if (r_ctrl_valid && !w_hs) w_ovr_nxt = 1'b1;
                    end else begin
                        w_lerr_nxt = 1'b1;
                    end
                end
            end
            if (w_fall) w_tdo_nxt = r_shreg[0];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_tdo        <= 1'b0;
            r_ctrl_out   <= '0;
            r_ctrl_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_len_err    <= 1'b0;
        end else begin
            r_shreg      <= w_shreg_nxt;
            r_cnt        <= w_cnt_nxt;
            r_tdo        <= w_tdo_nxt;
            r_ctrl_out   <= w_out_nxt;
            r_ctrl_valid <= w_valid_nxt;
            r_overrun    <= w_ovr_nxt;
            r_len_err    <= w_lerr_nxt;
        end
    end

    assign s_bscan.bscanid = C_BSCANID;
    assign s_bscan.tdo     = r_tdo;
    assign ctrl_out        = r_ctrl_out;
    assign ctrl_valid      = r_ctrl_valid;
    assign overrun         = r_overrun;
    assign len_err         = r_len_err;

endmodule

// File: tb/tb_bscan_user_responder.sv
// Randomized bench for bscan_user_responder: drives TCK-level scans through the S_BSCAN
// interface and compares against a queue-based model of a JTAG data register.
module tb_bscan_user_responder;

    localparam int unsigned W    = 32;
    localparam int unsigned SYNC = 2;
    localparam int unsigned H    = 6;  // aclk cycles per TCK half-period
    localparam logic [31:0] ID   = 32'h04C0_0101;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [W-1:0]  status_in = '0;
    logic [W-1:0]  ctrl_out;
    logic          ctrl_valid;
    logic          ctrl_ready = 1'b0;
    logic          overrun;
    logic          len_err;
    logic          err_clr = 1'b0;

    bscan_user_responder_if u_bscan ();

    bscan_user_responder #(
        .C_DR_WIDTH   (W),
        .C_BSCANID    (ID),
        .C_SYNC_STAGES(SYNC)
    ) u_dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_bscan   (u_bscan.slave),
        .status_in (status_in),
        .ctrl_out  (ctrl_out),
        .ctrl_valid(ctrl_valid),
        .ctrl_ready(ctrl_ready),
        .overrun   (overrun),
        .len_err   (len_err),
        .err_clr   (err_clr)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: data register as a bit queue, index 0 is the next bit out.
    bit           m_bits[$];
    int           m_cnt;
    bit           m_tdo;
    logic [W-1:0] m_out;
    bit           m_valid, m_ovr, m_lerr;
    bit           tb_id;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] m_word();
        logic [W-1:0] w;
        for (int i = 0; i < W; i++) w[i] = m_bits[i];
        return w;
    endfunction

    task automatic model_clear_dr();
        m_bits.delete();
        for (int i = 0; i < W; i++) m_bits.push_back(1'b0);
        m_cnt = 0;
        m_tdo = 1'b0;
    endtask

    task automatic model_reset();
        model_clear_dr();
        m_out = '0; m_valid = 0; m_ovr = 0; m_lerr = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".tdo"},     64'(u_bscan.tdo), 64'(m_tdo));
        check_eq({tag, ".out"},     64'(ctrl_out),    64'(m_out));
        check_eq({tag, ".valid"},   64'(ctrl_valid),  64'(m_valid));
        check_eq({tag, ".overrun"}, 64'(overrun),     64'(m_ovr));
        check_eq({tag, ".len_err"}, 64'(len_err),     64'(m_lerr));
        check_eq({tag, ".id"},      64'(u_bscan.bscanid), 64'(ID));
    endtask

    task automatic model_rise(input bit cap, input bit sh, input bit upd, input bit tdi,
                              input bit sel, input bit hs);
        bit loaded = 0;
        logic [W-1:0] cw;
        if (sel) begin
            if (cap) begin
                cw = tb_id ? W'(ID) : status_in;
                m_bits.delete();
                for (int i = 0; i < W; i++) m_bits.push_back(cw[i]);
                m_cnt = 0;
            end else if (sh) begin
                void'(m_bits.pop_front());
                m_bits.push_back(tdi);
                if (m_cnt < W + 1) m_cnt++;
            end else if (upd) begin
                if (m_cnt == W) begin
                    if (m_valid && !hs) m_ovr = 1;
                    m_out   = m_word();
                    m_valid = 1;
                    loaded  = 1;
                end else begin
                    m_lerr = 1;
                end
            end
        end
        if (hs && !loaded) m_valid = 0;
    endtask

    // One full TCK period; hs pulses ctrl_ready exactly on the aclk edge where the rise acts.
    task automatic tck_cycle(input bit cap, input bit sh, input bit upd, input bit tdi,
                             input bit sel, input bit hs, input string tag);
        @(negedge aclk);
        u_bscan.sel = sel; u_bscan.capture = cap; u_bscan.shift = sh;
        u_bscan.update = upd; u_bscan.tdi = tdi; u_bscan.bscanid_en = tb_id;
        repeat (H) @(negedge aclk);
        u_bscan.tck = 1'b1;
        if (hs) begin
            repeat (SYNC) @(posedge aclk);
            @(negedge aclk);
            ctrl_ready = 1'b1;
            @(negedge aclk);
            ctrl_ready = 1'b0;
            repeat (H - SYNC - 1) @(negedge aclk);
        end else begin
            repeat (H) @(negedge aclk);
        end
        model_rise(cap, sh, upd, tdi, sel, hs && m_valid);
        u_bscan.tck = 1'b0;
        repeat (H) @(negedge aclk);
        m_tdo = m_bits[0];
        check_outputs(tag);
    endtask

    task automatic scan(input logic [W-1:0] din, input int nsh, input bit do_upd,
                        input bit hs_upd, input string tag);
        tck_cycle(1, 0, 0, 0, 1, 0, {tag, ".cap"});
        for (int i = 0; i < nsh; i++)
            tck_cycle(0, 1, 0, (i < W) ? din[i] : 1'($urandom), 1, 0, {tag, ".sh"});
        if (do_upd) tck_cycle(0, 0, 1, 0, 1, hs_upd, {tag, ".upd"});
    endtask

    task automatic handshake(input string tag);
        @(negedge aclk);
        ctrl_ready = 1'b1;
        @(negedge aclk);
        ctrl_ready = 1'b0;
        m_valid = 0;
        check_outputs(tag);
    endtask

    task automatic clear_errors(input string tag);
        @(negedge aclk);
        err_clr = 1'b1;
        @(negedge aclk);
        err_clr = 1'b0;
        m_ovr = 0; m_lerr = 0;
        check_outputs(tag);
    endtask

    initial begin
        u_bscan.drck = 0; u_bscan.runtest = 0; u_bscan.tms = 0; u_bscan.reset = 0;
        u_bscan.sel = 0; u_bscan.capture = 0; u_bscan.shift = 0; u_bscan.update = 0;
        u_bscan.tdi = 0; u_bscan.tck = 0; u_bscan.bscanid_en = 0;
        tb_id = 0;
        model_reset();
        repeat (3) @(negedge aclk);
        check_outputs("reset");
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // LSB-first readout of a captured status word
        status_in = 32'hA5A5_0F0F;
        scan('0, 32, 0, 0, "capout");

        // Full update then handshake
        scan(32'hDEAD_BEEF, 32, 1, 0, "upd");
        handshake("hs");

        // Two updates without consuming: overrun
        scan(32'h1, 32, 1, 0, "ovr1");
        scan(32'h2, 32, 1, 0, "ovr2");
        clear_errors("errclr1");
        handshake("hs2");

        // Short, long and saturating-count scans
        scan(32'h1234_5678, 31, 1, 0, "len31");
        clear_errors("errclr2");
        scan(32'h8765_4321, 33, 1, 0, "len33");
        scan(32'hCAFE_F00D, 96, 1, 0, "len96");
        clear_errors("errclr3");

        // ID capture
        tb_id = 1;
        scan('0, 32, 0, 0, "idmode");
        tb_id = 0;

        // Update coinciding with a handshake of a pending word
        scan(32'h0BAD_F00D, 32, 1, 0, "pend");
        scan(32'h1357_9BDF, 32, 1, 1, "updhs");
        handshake("hs3");

        // s_reset mid-scan keeps ctrl state
        scan(32'h5A5A_5A5A, 32, 1, 0, "pre_sreset");
        status_in = 32'hFFFF_FFFF;
        tck_cycle(1, 0, 0, 0, 1, 0, "sr.cap");
        for (int i = 0; i < 5; i++) tck_cycle(0, 1, 0, 1, 1, 0, "sr.sh");
        @(negedge aclk);
        u_bscan.reset = 1'b1;
        repeat (H) @(negedge aclk);
        model_clear_dr();
        check_outputs("sreset");
        u_bscan.reset = 1'b0;
        repeat (H) @(negedge aclk);
        for (int i = 0; i < 3; i++) tck_cycle(0, 1, 0, 0, 1, 0, "sr.post");
        tck_cycle(0, 0, 1, 0, 1, 0, "sr.upd");

        // aresetn mid-scan
        tck_cycle(1, 0, 0, 0, 1, 0, "ar.cap");
        for (int i = 0; i < 10; i++) tck_cycle(0, 1, 0, 1, 1, 0, "ar.sh");
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        model_reset();
        check_outputs("aresetn");
        @(negedge aclk);
        aresetn = 1'b1;

        // Randomized scans
        for (int it = 0; it < 25; it++) begin
            int r;
            status_in = $urandom;
            tb_id = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 5);
            scan($urandom, (r == 0) ? 31 : (r == 1) ? 33 : 32,
                 ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0), "rnd");
            if ($urandom_range(0, 3) == 0) tck_cycle(0, 1, 0, 1, 0, 0, "rnd.nosel");
            if ($urandom_range(0, 2) == 0) handshake("rnd.hs");
            if ($urandom_range(0, 3) == 0) clear_errors("rnd.clr");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
